// File: rtl/bcd_down_timer_if.sv
// Control/status bundle for the BCD countdown timer.
// master drives the controls; slave is the timer itself.
interface bcd_down_timer_if #(
   parameter int DIGITS = 2
);
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic                  start;
   logic                  pause;
   logic                  tick;
   logic [4*DIGITS-1:0]   OUT;
   logic                  busy;
   logic                  done;

   modport master (
      output load, load_val, start, pause, tick,
      input  OUT, busy, done
   );

   modport slave (
      input  load, load_val, start, pause, tick,
      output OUT, busy, done
   );
endinterface

// File: rtl/bcd_down_timer.sv
// Multi-digit packed-BCD countdown timer.
// Load, start/pause control, one decrement per tick, done pulse at zero.
module bcd_down_timer #(
   parameter int DIGITS = 2
) (
   input logic         CLK,
   input logic         reset,
   bcd_down_timer_if.slave bus
);
   localparam int W = 4 * DIGITS;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] PAUSED = 2'd2;

   logic [1:0]   state;
   logic [W-1:0] count;
   logic         busy_r;
   logic         done_r;
   logic [W-1:0] clamped;
   logic [W-1:0] dec;
   logic         borrow;
   logic         is_zero;
   logic         is_one;
   logic         can_start;

   assign bus.OUT  = count;
   assign bus.busy = busy_r;
   assign bus.done = done_r;

   // Per-digit clamp of the preset and rippling-borrow BCD decrement.
   always_comb begin
      clamped = '0;
      dec     = '0;
      borrow  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.load_val[4*i +: 4] > 4'd9)
            clamped[4*i +: 4] = 4'd9;
         else
            clamped[4*i +: 4] = bus.load_val[4*i +: 4];

         if (!borrow) begin
            dec[4*i +: 4] = count[4*i +: 4];
         end else if (count[4*i +: 4] == 4'd0) begin
            dec[4*i +: 4] = 4'd9;
         end else begin
            dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
            borrow        = 1'b0;
         end
      end
   end

   assign is_zero   = (count == '0);
   assign is_one    = (count == W'(1));
   assign can_start = (state == IDLE) || (state == PAUSED);

   always_ff @(posedge CLK) begin
      if (reset) begin
         count  <= '0;
         state  <= IDLE;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (bus.load) begin
            count  <= clamped;
            state  <= IDLE;
            busy_r <= 1'b0;
         end else if (can_start && bus.start && !is_zero) begin
            state  <= RUN;
            busy_r <= 1'b1;
         end else if (state == RUN && is_zero) begin
            // Forced RUN at zero: fall back to IDLE without a pulse.
            state  <= IDLE;
            busy_r <= 1'b0;
         end else if (state == RUN && bus.pause) begin
            state  <= PAUSED;
            busy_r <= 1'b1;
         end else if (state == RUN && bus.tick) begin
            count <= dec;
            if (is_one) begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench for bcd_down_timer (DIGITS=2).
// Stimulus queues hand-computed results; a negedge monitor checks them.
module tb_bcd_down_timer;
   logic CLK;
   logic reset;

   bcd_down_timer_if #(.DIGITS(2)) bus ();

   bcd_down_timer #(.DIGITS(2)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [9:0] exp_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         step     = 0;
   bit         stim_done = 1'b0;
   bit         mon_done  = 1'b0;

   // Drive one cycle of inputs, then queue the state expected after the edge.
   task automatic cyc(
      input logic       rst,
      input logic       ld,
      input logic [7:0] lv,
      input logic       st,
      input logic       pa,
      input logic       tk,
      input logic [7:0] eo,
      input logic       eb,
      input logic       ed
   );
      reset        = rst;
      bus.load     = ld;
      bus.load_val = lv;
      bus.start    = st;
      bus.pause    = pa;
      bus.tick     = tk;
      @(posedge CLK);
      #1;
      exp_q.push_back({eo, eb, ed});
   endtask

   always @(negedge CLK) begin
      logic [9:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         step++;
         n_checks++;
         if ({bus.OUT, bus.busy, bus.done} !== e) begin
            n_fail++;
            $display("FAIL step%0d: OUT=%h busy=%b done=%b, expected OUT=%h busy=%b done=%b",
                     step, bus.OUT, bus.busy, bus.done, e[9:2], e[1], e[0]);
         end
      end else if (stim_done) begin
         mon_done = 1'b1;
      end
   end

   initial begin
      reset        = 1'b1;
      bus.load     = 1'b0;
      bus.load_val = 8'h00;
      bus.start    = 1'b0;
      bus.pause    = 1'b0;
      bus.tick     = 1'b0;
      @(negedge CLK);

      //  rst ld  lv     st pa tk  OUT    busy done
      cyc(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
      cyc(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
      cyc(0, 1, 8'h25, 0, 0, 0, 8'h25, 0, 0);
      // count 3 down to zero
      cyc(0, 1, 8'h03, 0, 0, 0, 8'h03, 0, 0);
      cyc(0, 0, 8'h00, 1, 0, 0, 8'h03, 1, 0);
      cyc(0, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0);
      cyc(0, 0, 8'h00, 0, 0, 1, 8'h01, 1, 0);
      cyc(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 1);
      cyc(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
      // borrow, then start at zero ignored
      cyc(0, 1, 8'h10, 0, 0, 0, 8'h10, 0, 0);
      cyc(0, 0, 8'h00, 1, 0, 0, 8'h10, 1, 0);
      cyc(0, 0, 8'h00, 0, 0, 1, 8'h09, 1, 0);
      cyc(0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
      cyc(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
      cyc(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
      // pause / resume, start+tick does not decrement
      cyc(0, 1, 8'h20, 0, 0, 0, 8'h20, 0, 0);
      cyc(0, 0, 8'h00, 0, 1, 0, 8'h20, 0, 0);
      cyc(0, 0, 8'h00, 1, 0, 1, 8'h20, 1, 0);
      cyc(0, 0, 8'h00, 1, 0, 1, 8'h19, 1, 0);
      cyc(0, 0, 8'h00, 0, 0, 1, 8'h18, 1, 0);
      cyc(0, 0, 8'h00, 0, 1, 1, 8'h18, 1, 0);
      cyc(0, 0, 8'h00, 0, 0, 1, 8'h18, 1, 0);
      cyc(0, 0, 8'h00, 0, 1, 1, 8'h18, 1, 0);
      cyc(0, 0, 8'h00, 1, 0, 1, 8'h18, 1, 0);
      cyc(0, 0, 8'h00, 0, 0, 1, 8'h17, 1, 0);
      // clamp and load overriding a tick
      cyc(0, 1, 8'hA3, 0, 0, 0, 8'h93, 0, 0);
      cyc(0, 1, 8'hAB, 0, 0, 0, 8'h99, 0, 0);
      cyc(0, 0, 8'h00, 1, 0, 0, 8'h99, 1, 0);
      cyc(0, 0, 8'h00, 0, 0, 1, 8'h98, 1, 0);
      cyc(0, 1, 8'h05, 0, 0, 1, 8'h05, 0, 0);
      cyc(0, 0, 8'h00, 1, 0, 0, 8'h05, 1, 0);
      cyc(0, 0, 8'h00, 0, 0, 1, 8'h04, 1, 0);
      // reset mid-RUN
      cyc(1, 0, 8'h00, 1, 0, 1, 8'h00, 0, 0);
      cyc(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
      cyc(0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 0);
      cyc(1, 1, 8'h42, 0, 0, 0, 8'h00, 0, 0);
      cyc(0, 1, 8'h01, 0, 0, 0, 8'h01, 0, 0);
      cyc(0, 0, 8'h00, 1, 0, 0, 8'h01, 1, 0);
      cyc(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 1);
      cyc(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);

      bus.tick  = 1'b0;
      bus.start = 1'b0;
      stim_done = 1'b1;
      for (int i = 0; i < 20 && !mon_done; i++) @(posedge CLK);
      if (!mon_done) begin
         $display("FAIL drain: queue still holds %0d entries, required 0", exp_q.size());
         $fatal(1, "scoreboard did not drain");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
